// File: rtl/fifo_access_sched.sv
// Round-robin write / priority read scheduler in front of a shared synchronous FIFO.
// Optional SCHED_STATS_EN adds a saturating producer stall counter (stall_cnt).

module fifo_sched_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 2,
    parameter int LANE       = 0
) (
    input  logic                  wr_issue,
    input  logic [ID_W-1:0]       winner,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_gated
);
    assign ready      = wr_issue && (winner == ID_W'(LANE));
    assign data_gated = ready ? data : '0;
endmodule

module fifo_access_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            rd_req,
    output logic                            rd_ack,
    output logic                            rd_data_valid,
    output logic                            fifo_wr_n,
    output logic                            fifo_rd_n,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CAP   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [ST_W-1:0]  ST_MAX = ST_W'(STARVE_LIMIT);

    typedef struct packed {
        logic            wr;
        logic            rd;
        logic [ID_W-1:0] idx;
    } sched_op_t;

    logic [ID_W-1:0] rr_ptr;
    logic [ST_W-1:0] starve_cnt;
    logic            wr_elig, rd_elig;
    sched_op_t       op;
    int              scan_idx;
    logic            found;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_din;

    assign wr_elig = (|req_valid) && (count < CAP);
    assign rd_elig = rd_req && (count != '0);

    // First valid producer at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        scan_idx = 0;
        op.idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                op.idx = ID_W'(scan_idx);
            end
        end
        // Reads win unless the pending write has already lost STARVE_LIMIT times.
        op.wr = rst_n && wr_elig && (!rd_elig || starve_cnt == ST_MAX);
        op.rd = rst_n && rd_elig && !op.wr;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_sched_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_W       (ID_W),
            .LANE       (i)
        ) u_lane (
            .wr_issue   (op.wr),
            .winner     (op.idx),
            .data       (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .ready      (req_ready[i]),
            .data_gated (lane_din[i])
        );
    end

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_REQ; i++) fifo_din = fifo_din | lane_din[i];
    end

    assign fifo_wr_n = !op.wr;
    assign fifo_rd_n = !op.rd;
    assign rd_ack    = op.rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count         <= '0;
            rr_ptr        <= '0;
            grant_id      <= '0;
            starve_cnt    <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= op.rd;
            if (op.wr)      count <= count + 1'b1;
            else if (op.rd) count <= count - 1'b1;
            if (op.wr) begin
                grant_id <= op.idx;
                rr_ptr   <= (op.idx == ID_W'(NUM_REQ - 1)) ? '0 : op.idx + 1'b1;
            end
            if (op.wr || !wr_elig)
                starve_cnt <= '0;
            else if (op.rd && starve_cnt != ST_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if ((|req_valid) && !op.wr && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed bench for fifo_access_sched with a behavioural FIFO behind it.
module tb_fifo_access_sched;
    localparam int NR = 4, DW = 8, DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic             rd_req = 1'b0;
    logic [NR-1:0]    req_ready;
    logic             rd_ack, rd_data_valid, fifo_wr_n, fifo_rd_n;
    logic [DW-1:0]    fifo_din;
    logic [4:0]       count;
    logic [1:0]       grant_id;
`ifdef SCHED_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    fifo_access_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .fifo_wr_n(fifo_wr_n), .fifo_rd_n(fifo_rd_n),
        .fifo_din(fifo_din), .count(count), .grant_id(grant_id)
`ifdef SCHED_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: capacity DEPTH-1, registered dout.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wp = '0, rp = '0;
    logic [DW-1:0] dout = '0;
    int            fcnt = 0;
    int            lost = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; fcnt <= 0;
        end else begin
            if (!fifo_wr_n && fcnt < DEPTH - 1) begin mem[wp] <= fifo_din; wp <= wp + 4'd1; end
            if (!fifo_rd_n && fcnt > 0) begin dout <= mem[rp]; rp <= rp + 4'd1; end
            fcnt <= fcnt + ((!fifo_wr_n && fcnt < DEPTH - 1) ? 1 : 0) - ((!fifo_rd_n && fcnt > 0) ? 1 : 0);
        end
    end
    always @(negedge clk)
        if (rst_n && ((!fifo_wr_n && fcnt >= DEPTH - 1) || (!fifo_rd_n && fcnt == 0))) lost <= lost + 1;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) chk("mutex", 32'(fifo_wr_n | fifo_rd_n), 32'd1);

    int acc;
    logic [7:0] d;
    logic [3:0] rd_pat, wr_pat;

    initial begin
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        // T1 reset with everything requesting
        req_valid = 4'hF; rd_req = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_wr_n", 32'(fifo_wr_n), 32'd1);
            chk("t1_rd_n", 32'(fifo_rd_n), 32'd1);
            chk("t1_ready", 32'(req_ready), 32'd0);
            chk("t1_din", 32'(fifo_din), 32'd0);
            tick;
        end
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_grant", 32'(grant_id), 32'd0);
        chk("t1_rdv", 32'(rd_data_valid), 32'd0);
        req_valid = '0; rd_req = 1'b0; rst_n = 1'b1;
        tick;

        // T2 round robin across all four producers
        req_valid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1 << (g % 4)));
            chk("t2_wr_n", 32'(fifo_wr_n), 32'd0);
            tick;
            chk("t2_grant", 32'(grant_id), 32'(g % 4));
        end
        req_valid = '0;
        chk("t2_count", 32'(count), 32'd8);
        rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_rd_ack", 32'(rd_ack), 32'd1);
            tick;
            chk("t2_rdv", 32'(rd_data_valid), 32'd1);
            chk("t2_dout", 32'(dout), 32'(8'hA0 + k % 4));
        end
        rd_req = 1'b0;
        tick;
        chk("t2_empty", 32'(count), 32'd0);
        chk("t2_rdv_off", 32'(rd_data_valid), 32'd0);

        // T3 fill through producer 2 only
        req_valid = 4'b0100; d = 8'h00; acc = 0;
        for (int c = 0; c < 20; c++) begin
            req_data[16 +: 8] = d;
            #1;
            if (req_ready[2]) begin acc++; d = d + 8'd1; end
            tick;
        end
        chk("t3_accepted", 32'(acc), 32'd15);
        chk("t3_count", 32'(count), 32'd15);
        #1;
        chk("t3_ready_off", 32'(req_ready), 32'd0);
        chk("t3_wr_n", 32'(fifo_wr_n), 32'd1);
        chk("t3_grant", 32'(grant_id), 32'd2);
`ifdef SCHED_STATS_EN
        chk("t3_stall", 32'(stall_cnt), 32'd5);
`endif

        // Drain to 10, then T4 starvation guard
        req_valid = '0; rd_req = 1'b1;
        for (int c = 0; c < 5; c++) tick;
        chk("t4_count0", 32'(count), 32'd10);
        req_valid = 4'b0010; req_data[8 +: 8] = 8'h5C;
        rd_pat = 4'b1111; wr_pat = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t4_rd_ack", 32'(rd_ack), (c == 4) ? 32'd0 : 32'd1);
            chk("t4_ready", 32'(req_ready), (c == 4) ? 32'd2 : 32'd0);
            tick;
        end
        chk("t4_count1", 32'(count), 32'd6);

        req_valid = '0;
        for (int c = 0; c < 8; c++) tick;
        chk("t5_count0", 32'(count), 32'd0);

        // T5 read request into an empty FIFO
        req_valid = 4'b0001; req_data[0 +: 8] = 8'hA5;
        #1;
        chk("t5_rd_ack0", 32'(rd_ack), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = '0;
        #1;
        chk("t5_rd_ack1", 32'(rd_ack), 32'd1);
        tick;
        chk("t5_rdv", 32'(rd_data_valid), 32'd1);
        chk("t5_dout", 32'(dout), 32'hA5);
        rd_req = 1'b0;

        // T6 reset with 7 words stored and a read in flight
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b0010;
        for (int c = 0; c < 7; c++) tick;
        req_valid = '0;
        chk("t6_count7", 32'(count), 32'd7);
        chk("t6_grant1", 32'(grant_id), 32'd1);
        rd_req = 1'b1;
        #1;
        chk("t6_rd_ack", 32'(rd_ack), 32'd1);
        tick;
        chk("t6_rdv_pre", 32'(rd_data_valid), 32'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_grant", 32'(grant_id), 32'd0);
        chk("t6_rdv", 32'(rd_data_valid), 32'd0);
`ifdef SCHED_STATS_EN
        chk("t6_stall", 32'(stall_cnt), 32'd0);
`endif
        #1;
        chk("t6_no_rd0", 32'(rd_ack), 32'd0);
        tick;
        chk("t6_no_rd1", 32'(rd_ack), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("t6_rr0", 32'(req_ready), 32'd1);
        tick;
        req_valid = '0;
        #1;
        chk("t6_rd_after_wr", 32'(rd_ack), 32'd1);
        tick;
        chk("t6_dout", 32'(dout), 32'hA0);
        rd_req = 1'b0;
        tick;
        chk("lost_ops", 32'(lost), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
